// File: rtl/spi_lcd_receiver_if.sv
// Receive stream from the SPI LCD receiver: head-of-FIFO byte, its data/command
// tag, and a valid/ready handshake with the consumer.
interface spi_lcd_receiver_if;
   logic [7:0] rx_data;
   logic       rx_dc;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_dc, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_dc, input rx_valid, output rx_ready);
endinterface

// File: rtl/spi_lcd_receiver.sv
// Mode-0 SPI slave for an LCD link: oversamples the SPI pins in the clk domain,
// assembles MSB-first bytes tagged with lcd_dc, and queues them in a small FIFO.
module spi_lcd_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               spi_clk,
   input  logic               spi_mosi,
   input  logic               spi_cs_n,
   input  logic               lcd_dc,
   spi_lcd_receiver_if.master rx,
   output logic               rx_busy,
   output logic               rx_overflow,
   output logic               rx_frame_err
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] clk_sync, mosi_sync, cs_sync, dc_sync;
   logic                   clk_prev;
   logic                   spi_clk_s, mosi_s, cs_n_s, dc_s, spi_rise;

   logic [2:0]             bit_cnt;
   logic [7:0]             shift_reg;
   logic                   push_req;
   logic [8:0]             push_entry;

   logic [8:0]             mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic [PTR_W:0]         count;
   logic                   fifo_valid, full, pop, push_ok;

   // Synchronizer reset values match an idle, deselected bus.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync  <= '0;
         mosi_sync <= '0;
         cs_sync   <= '1;
         dc_sync   <= '0;
         clk_prev  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values; blocking here would collapse the chain.
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         dc_sync   <= {dc_sync[SYNC_STAGES-2:0], lcd_dc};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign spi_clk_s = clk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign cs_n_s    = cs_sync[SYNC_STAGES-1];
   assign dc_s      = dc_sync[SYNC_STAGES-1];
   assign spi_rise  = spi_clk_s && !clk_prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         IDLE:    if (!cs_n_s) state_nxt = ACTIVE;
         ACTIVE:  if (cs_n_s)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rx_busy = (state == ACTIVE);
   end

   // Bit assembly; push_req and rx_frame_err are single-cycle strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt      <= '0;
         shift_reg    <= '0;
         push_req     <= 1'b0;
         push_entry   <= '0;
         rx_frame_err <= 1'b0;
      end else begin
         push_req     <= 1'b0;
         rx_frame_err <= 1'b0;
         if (state == IDLE) begin
            if (!cs_n_s) bit_cnt <= '0;
         end else if (cs_n_s) begin
            rx_frame_err <= (bit_cnt != 3'd0);
         end else if (spi_rise) begin
            shift_reg <= {shift_reg[6:0], mosi_s};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               push_req   <= 1'b1;
               push_entry <= {dc_s, shift_reg[6:0], mosi_s};
            end
         end
      end
   end

   assign fifo_valid = (count != '0);
   assign full       = (count == FULL_CNT);
   assign pop        = fifo_valid && rx.rx_ready;
   // A full FIFO still takes a push when the head leaves on the same edge.
   assign push_ok    = push_req && (!full || pop);

   // NOTE: storage is not reset; the output mux hides stale entries while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         rx_overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         rx_overflow <= push_req && full && !pop;
      end
   end

   assign rx.rx_valid            = fifo_valid;
   assign {rx.rx_dc, rx.rx_data} = fifo_valid ? mem[rd_ptr] : 9'h000;
endmodule

// File: tb/tb_spi_lcd_receiver.sv
// Bench for spi_lcd_receiver: a bit-level SPI master plus a queue model of the
// delivered {dc, byte} stream, overflow drops and framing errors.
module tb_spi_lcd_receiver;
   localparam int SYNC_STAGES = 2;
   localparam int FIFO_DEPTH  = 4;

   logic clk      = 1'b0;
   logic reset_n  = 1'b0;
   logic spi_clk  = 1'b0;
   logic spi_mosi = 1'b0;
   logic spi_cs_n = 1'b1;
   logic lcd_dc   = 1'b0;
   logic rx_busy, rx_overflow, rx_frame_err;

   spi_lcd_receiver_if rx_if ();

   spi_lcd_receiver #(.SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .spi_clk      (spi_clk),
      .spi_mosi     (spi_mosi),
      .spi_cs_n     (spi_cs_n),
      .lcd_dc       (lcd_dc),
      .rx           (rx_if.master),
      .rx_busy      (rx_busy),
      .rx_overflow  (rx_overflow),
      .rx_frame_err (rx_frame_err)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [8:0] exp_q[$];
   int         exp_ovf = 0, exp_ferr = 0;
   int         ovf_cycles = 0, ferr_cycles = 0, pop_count = 0;
   int         half = 4;
   logic       prev_hold = 1'b0;
   logic [8:0] prev_head = '0;
   logic [8:0] mon_got, mon_exp;

   // Sampled 2 time units before each rising edge, after the bench has driven inputs.
   always @(negedge clk) begin
      #3;
      if (!reset_n) begin
         prev_hold = 1'b0;
      end else begin
         mon_got = {rx_if.rx_dc, rx_if.rx_data};
         if (rx_overflow)  ovf_cycles++;
         if (rx_frame_err) ferr_cycles++;
         if (prev_hold) begin
            checks++;
            if ({rx_if.rx_valid, mon_got} !== {1'b1, prev_head}) begin
               errors++;
               $display("FAIL hold_stable got valid=%0b head=%03h want valid=1 head=%03h",
                        rx_if.rx_valid, mon_got, prev_head);
            end
         end
         if (rx_if.rx_valid && rx_if.rx_ready) begin
            checks++;
            pop_count++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pop_unexpected got head=%03h want no entry", mon_got);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_got !== mon_exp) begin
                  errors++;
                  $display("FAIL pop_order got head=%03h want %03h", mon_got, mon_exp);
               end
            end
         end
         prev_hold = rx_if.rx_valid && !rx_if.rx_ready;
         prev_head = mon_got;
      end
   end

   task automatic model_push(input logic [8:0] e);
      if (exp_q.size() >= FIFO_DEPTH) exp_ovf++;
      else                            exp_q.push_back(e);
   endtask

   task automatic begin_frame();
      spi_clk  = 1'b0;
      spi_cs_n = 1'b0;
      repeat (half) @(negedge clk);
   endtask

   task automatic end_frame();
      spi_clk = 1'b0;
      repeat (half) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (half + SYNC_STAGES + 4) @(negedge clk);
   endtask

   // mode 1: check rx_valid latency after the last edge (FIFO empty beforehand)
   // mode 2: pulse rx_ready for exactly the edge on which the FIFO takes the push
   task automatic send_byte(input logic [7:0] data, input logic dc, input int nbits, input int mode);
      for (int b = 0; b < nbits; b++) begin
         spi_clk  = 1'b0;
         spi_mosi = data[7-b];
         lcd_dc   = dc;
         repeat (half) @(negedge clk);
         spi_clk = 1'b1;
         for (int i = 1; i <= half; i++) begin
            @(negedge clk);
            if (b == 7 && mode == 2) rx_if.rx_ready = (i == SYNC_STAGES + 1);
            if (b == 7 && mode == 1 && (i == SYNC_STAGES + 1 || i == SYNC_STAGES + 2)) begin
               #1;
               checks++;
               if (rx_if.rx_valid !== (i == SYNC_STAGES + 2)) begin
                  errors++;
                  $display("FAIL valid_latency cycle %0d got valid=%0b want %0b",
                           i, rx_if.rx_valid, (i == SYNC_STAGES + 2));
               end
            end
         end
      end
      if (nbits == 8) model_push({dc, data});
   endtask

   task automatic drain(input int budget, output bit ok);
      rx_if.rx_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #4;
         if (!rx_if.rx_valid && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rx_if.rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({rx_if.rx_valid, rx_if.rx_dc, rx_if.rx_data, rx_busy, rx_overflow, rx_frame_err} !== 13'h0) begin
         errors++;
         $display("FAIL reset_outputs got valid=%0b dc=%0b data=%02h busy=%0b ovf=%0b ferr=%0b want all 0",
                  rx_if.rx_valid, rx_if.rx_dc, rx_if.rx_data, rx_busy, rx_overflow, rx_frame_err);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_two_bytes();
      bit ok;
      half = 4;
      rx_if.rx_ready = 1'b1;
      begin_frame();
      #1;
      checks++;
      if (rx_busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_active got %0b want 1", rx_busy);
      end
      send_byte(8'hA5, 1'b1, 8, 1);
      send_byte(8'h3C, 1'b0, 8, 0);
      end_frame();
      checks++;
      if (rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_idle got %0b want 0", rx_busy);
      end
      drain(50, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL two_bytes_drain got %0d entries left want 0", exp_q.size());
      end
      checks++;
      if (ovf_cycles != exp_ovf || ferr_cycles != exp_ferr) begin
         errors++;
         $display("FAIL two_bytes_pulses got ovf=%0d ferr=%0d want ovf=%0d ferr=%0d",
                  ovf_cycles, ferr_cycles, exp_ovf, exp_ferr);
      end
   endtask

   task automatic test_overflow();
      bit ok;
      int pops0;
      rx_if.rx_ready = 1'b0;
      begin_frame();
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'($urandom_range(0, 1)), 8, 0);
      end_frame();
      checks++;
      if (ovf_cycles != exp_ovf || exp_ovf == 0) begin
         errors++;
         $display("FAIL overflow_pulse got %0d cycles want %0d", ovf_cycles, exp_ovf);
      end
      checks++;
      if ({rx_if.rx_valid, rx_if.rx_dc, rx_if.rx_data} !== {1'b1, exp_q[0]}) begin
         errors++;
         $display("FAIL overflow_head got valid=%0b head=%03h want valid=1 head=%03h",
                  rx_if.rx_valid, {rx_if.rx_dc, rx_if.rx_data}, exp_q[0]);
      end
      pops0 = pop_count;
      drain(50, ok);
      checks++;
      if (!ok || pop_count - pops0 != FIFO_DEPTH) begin
         errors++;
         $display("FAIL overflow_drain got %0d pops want %0d", pop_count - pops0, FIFO_DEPTH);
      end
   endtask

   task automatic test_frame_err();
      bit ok;
      int pops0 = pop_count;
      rx_if.rx_ready = 1'b1;
      begin_frame();
      send_byte(8'hFF, 1'b1, 5, 0);
      end_frame();
      exp_ferr++;
      checks++;
      if (ferr_cycles != exp_ferr || rx_if.rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL frame_err_pulse got %0d cycles valid=%0b want %0d cycles valid=0",
                  ferr_cycles, rx_if.rx_valid, exp_ferr);
      end
      begin_frame();
      send_byte(8'h5A, 1'b0, 8, 0);
      end_frame();
      drain(50, ok);
      checks++;
      if (!ok || pop_count - pops0 != 1 || ferr_cycles != exp_ferr) begin
         errors++;
         $display("FAIL frame_err_recover got pops=%0d ferr=%0d want pops=1 ferr=%0d",
                  pop_count - pops0, ferr_cycles, exp_ferr);
      end
   endtask

   task automatic test_full_simultaneous();
      bit ok;
      int pops0;
      rx_if.rx_ready = 1'b0;
      begin_frame();
      for (int i = 0; i < FIFO_DEPTH; i++) send_byte(8'($urandom), 1'($urandom_range(0, 1)), 8, 0);
      send_byte(8'($urandom), 1'($urandom_range(0, 1)), 8, 2);
      end_frame();
      checks++;
      if (ovf_cycles != exp_ovf) begin
         errors++;
         $display("FAIL full_simul_overflow got %0d cycles want %0d", ovf_cycles, exp_ovf);
      end
      pops0 = pop_count;
      drain(50, ok);
      checks++;
      if (!ok || pop_count - pops0 != FIFO_DEPTH) begin
         errors++;
         $display("FAIL full_simul_occupancy got %0d pops want %0d", pop_count - pops0, FIFO_DEPTH);
      end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      int ferr0;
      rx_if.rx_ready = 1'b0;
      begin_frame();
      send_byte(8'h77, 1'b1, 8, 0);
      send_byte(8'hE0, 1'b0, 3, 0);
      ferr0 = ferr_cycles;
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({rx_if.rx_valid, rx_if.rx_dc, rx_if.rx_data, rx_busy, rx_overflow, rx_frame_err} !== 13'h0) begin
         errors++;
         $display("FAIL reset_mid_outputs got valid=%0b dc=%0b data=%02h busy=%0b ovf=%0b ferr=%0b want all 0",
                  rx_if.rx_valid, rx_if.rx_dc, rx_if.rx_data, rx_busy, rx_overflow, rx_frame_err);
      end
      exp_q.delete();
      spi_clk  = 1'b0;
      spi_cs_n = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      rx_if.rx_ready = 1'b1;
      begin_frame();
      send_byte(8'hC3, 1'b1, 8, 1);
      end_frame();
      drain(50, ok);
      checks++;
      if (!ok || ferr_cycles != ferr0) begin
         errors++;
         $display("FAIL reset_mid_recover got left=%0d ferr=%0d want left=0 ferr=%0d",
                  exp_q.size(), ferr_cycles, ferr0);
      end
   endtask

   task automatic test_max_rate();
      bit ok;
      int pops0 = pop_count;
      half = 2;
      rx_if.rx_ready = 1'b1;
      begin_frame();
      for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'($urandom_range(0, 1)), 8, 0);
      end_frame();
      drain(50, ok);
      checks++;
      if (!ok || pop_count - pops0 != 16 || ovf_cycles != exp_ovf) begin
         errors++;
         $display("FAIL max_rate got pops=%0d ovf=%0d want pops=16 ovf=%0d",
                  pop_count - pops0, ovf_cycles, exp_ovf);
      end
      half = 4;
   endtask

   task automatic test_random_ready();
      bit ok;
      bit done = 1'b0;
      int pops0 = pop_count;
      fork
         begin
            for (int f = 0; f < 2; f++) begin
               begin_frame();
               for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'($urandom_range(0, 1)), 8, 0);
               end_frame();
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               rx_if.rx_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      drain(50, ok);
      checks++;
      if (!ok || pop_count - pops0 != 6 || ovf_cycles != exp_ovf || ferr_cycles != exp_ferr) begin
         errors++;
         $display("FAIL random_ready got pops=%0d ovf=%0d ferr=%0d want pops=6 ovf=%0d ferr=%0d",
                  pop_count - pops0, ovf_cycles, ferr_cycles, exp_ovf, exp_ferr);
      end
   endtask

   initial begin
      rx_if.rx_ready = 1'b0;
      test_reset();
      test_two_bytes();
      test_overflow();
      test_frame_err();
      test_full_simultaneous();
      test_reset_mid_frame();
      test_max_rate();
      test_random_ready();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
